// File: rtl/lab3_sequence_generator.sv
// Serial pattern source: shifts a latched WIDTH-bit pattern out MSB-first for
// repeat_n+1 frames, with one idle gap between frames and a done pulse at the end.
module lab3_sequence_generator #(
   parameter int WIDTH = 8,
   parameter int CNT_W = 4
) (
   input  logic             clock,
   input  logic             reset,
   input  logic             start,
   input  logic [WIDTH-1:0] pattern,
   input  logic [CNT_W-1:0] repeat_n,
   output logic             x,
   output logic             valid,
   output logic             busy,
   output logic             done,
   output logic [1:0]       fsm_state
);

   localparam int BW = $clog2(WIDTH);
   localparam logic [BW-1:0] LAST_BIT = BW'(WIDTH - 1);

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      SEND = 2'd1,
      GAP  = 2'd2,
      DONE = 2'd3
   } state_t;

   state_t           state;
   logic [WIDTH-1:0] pat_reg;
   logic [WIDTH-1:0] shift_reg;
   logic [BW-1:0]    bit_cnt;
   logic [CNT_W-1:0] frame_cnt;

   assign fsm_state = state;

   // Outputs are registered from the current state, so they trail the state by
   // one cycle; done=1 marks the visible DONE cycle, in which start is refused.
   always_ff @(posedge clock) begin
      if (!reset) begin
         state     <= IDLE;
         pat_reg   <= '0;
         shift_reg <= '0;
         bit_cnt   <= '0;
         frame_cnt <= '0;
         x         <= 1'b0;
         valid     <= 1'b0;
         busy      <= 1'b0;
         done      <= 1'b0;
      end else begin
         case (state)
            IDLE: begin
               x     <= 1'b0;
               valid <= 1'b0;
               busy  <= 1'b0;
               done  <= 1'b0;
               if (start && !done) begin
                  pat_reg   <= pattern;
                  shift_reg <= pattern;
                  frame_cnt <= repeat_n;
                  bit_cnt   <= LAST_BIT;
                  state     <= SEND;
               end
            end
            SEND: begin
               x         <= shift_reg[WIDTH-1];
               valid     <= 1'b1;
               busy      <= 1'b1;
               done      <= 1'b0;
               shift_reg <= {shift_reg[WIDTH-2:0], 1'b0};
               bit_cnt   <= bit_cnt - 1'b1;
               if (bit_cnt == '0) begin
                  if (frame_cnt != '0) begin
                     frame_cnt <= frame_cnt - 1'b1;
                     shift_reg <= pat_reg;
                     bit_cnt   <= LAST_BIT;
                     state     <= GAP;
                  end else begin
                     state <= DONE;
                  end
               end
            end
            GAP: begin
               x     <= 1'b0;
               valid <= 1'b0;
               busy  <= 1'b1;
               done  <= 1'b0;
               state <= SEND;
            end
            DONE: begin
               x     <= 1'b0;
               valid <= 1'b0;
               busy  <= 1'b1;
               done  <= 1'b1;
               state <= IDLE;
            end
            default: state <= IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_lab3_sequence_generator.sv
// Directed bench for lab3_sequence_generator; expected outputs are hand-derived
// per cycle as {x, valid, busy, done}.
module tb_lab3_sequence_generator;

   logic       clock;
   logic       reset;
   logic       start;
   logic [7:0] pattern;
   logic [3:0] repeat_n;
   logic       x;
   logic       valid;
   logic       busy;
   logic       done;
   logic [1:0] fsm_state;

   int checks = 0;
   int passes = 0;
   int fails  = 0;

   lab3_sequence_generator #(.WIDTH(8), .CNT_W(4)) dut (
      .clock     (clock),
      .reset     (reset),
      .start     (start),
      .pattern   (pattern),
      .repeat_n  (repeat_n),
      .x         (x),
      .valid     (valid),
      .busy      (busy),
      .done      (done),
      .fsm_state (fsm_state)
   );

   initial clock = 1'b0;
   always #5 clock = ~clock;

   // Advance one rising edge and settle; inputs change and outputs are sampled here.
   task automatic tick();
      @(posedge clock);
      #1;
   endtask

   task automatic chk(input string tag, input logic [3:0] expv);
      logic [3:0] obs;
      obs = {x, valid, busy, done};
      checks++;
      assert (obs === expv) passes++;
      else begin
         fails++;
         $error("FAIL %s t=%0t obs{x,v,b,d}=%b exp=%b", tag, $time, obs, expv);
      end
   endtask

   task automatic send_frame(input string tag, input logic [7:0] p);
      for (int i = 7; i >= 0; i--) begin
         tick();
         chk(tag, {p[i], 3'b110});
      end
   endtask

   task automatic launch(input logic [7:0] p, input logic [3:0] n);
      pattern  = p;
      repeat_n = n;
      start    = 1'b1;
      tick();
      start    = 1'b0;
      chk("launch_cycle", 4'b0000);
   endtask

   initial begin
      // Reset held with start asserted
      reset    = 1'b0;
      start    = 1'b1;
      pattern  = 8'hFF;
      repeat_n = 4'd0;
      for (int i = 0; i < 3; i++) begin
         tick();
         chk("reset_hold", 4'b0000);
      end
      reset = 1'b1;
      start = 1'b0;
      for (int i = 0; i < 2; i++) begin
         tick();
         chk("reset_release", 4'b0000);
      end

      // Single frame
      launch(8'b1001_1010, 4'd0);
      send_frame("single_bit", 8'b1001_1010);
      tick(); chk("single_done", 4'b0011);
      tick(); chk("single_idle", 4'b0000);
      tick(); chk("single_idle2", 4'b0000);

      // Three frames, with start pulse and pattern change mid-burst
      launch(8'b1100_0001, 4'd2);
      for (int f = 0; f < 3; f++) begin
         for (int i = 7; i >= 0; i--) begin
            if (f == 0 && i == 4) begin
               start   = 1'b1;
               pattern = 8'h00;
               repeat_n = 4'd5;
            end else begin
               start = 1'b0;
            end
            tick();
            chk("rep_bit", {pattern_bit(8'b1100_0001, i), 3'b110});
         end
         if (f < 2) begin
            tick();
            chk("rep_gap", 4'b0010);
         end
      end
      tick(); chk("rep_done", 4'b0011);
      for (int i = 0; i < 12; i++) begin
         tick();
         chk("rep_no_rerun", 4'b0000);
      end

      // Reset after the 3rd bit of frame 1, then fresh start
      launch(8'b1001_1010, 4'd1);
      tick(); chk("mid_b0", 4'b1110);
      tick(); chk("mid_b1", 4'b0110);
      tick(); chk("mid_b2", 4'b0110);
      reset = 1'b0;
      start = 1'b1;
      tick(); chk("mid_reset", 4'b0000);
      reset = 1'b1;
      start = 1'b0;
      tick(); chk("mid_release", 4'b0000);
      launch(8'hA5, 4'd0);
      send_frame("fresh_bit", 8'hA5);
      tick(); chk("fresh_done", 4'b0011);

      // Back-to-back: start held through the done cycle and the first idle cycle
      pattern  = 8'h3C;
      repeat_n = 4'd0;
      start    = 1'b1;
      tick(); chk("b2b_ignored", 4'b0000);
      tick(); chk("b2b_accept", 4'b0000);
      start = 1'b0;
      send_frame("b2b_bit", 8'h3C);
      tick(); chk("b2b_done", 4'b0011);
      for (int i = 0; i < 4; i++) begin
         tick();
         chk("b2b_idle", 4'b0000);
      end

      // All-ones repeat count: 16 frames, no counter wrap
      launch(8'h81, 4'hF);
      for (int f = 0; f < 16; f++) begin
         send_frame("max_bit", 8'h81);
         if (f < 15) begin
            tick();
            chk("max_gap", 4'b0010);
         end
      end
      tick(); chk("max_done", 4'b0011);
      tick(); chk("max_idle", 4'b0000);

      $display("%0d/%0d checks passed", passes, checks);
      $finish;
   end

   function automatic logic pattern_bit(input logic [7:0] p, input int i);
      return p[i];
   endfunction

   initial begin
      #200000;
      $display("FAIL timeout t=%0t", $time);
      $fatal(1, "timeout");
   end

endmodule
